apb_master_mc: RTL and testbench
================================

Name: apb_master_mc

Overview:
- Parametrised APB4 master bridge and the successor to the single-slave APB master.
- Takes one request at a time over a valid/ready command interface and decodes the target slave from the address into NUM_SLAVES regions.
- Runs the SETUP/ACCESS protocol with PREADY wait states, PSTRB byte strobes and PSLVERR capture.
- Returns a single-cycle response pulse. Sits between the system-side controller and the APB slave fabric.

Parameters:
- ADDR_W, 8, address width.
- DATA_W, 8, data width; must be a multiple of 8.
- NUM_SLAVES, 3, number of PSEL lines; range 1..8.
- REGION_BITS, 6, log2 of each slave's address span (64 locations).
- TIMEOUT, 16, PREADY wait-cycle limit; used only when APB_TIMEOUT_EN is defined.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- req_valid  in  1  command valid.
- req_ready  out  1  bridge can accept a command.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  write data.
- req_strb  in  DATA_W/8  write byte enables.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  read data; 0 for writes and on error.
- rsp_err  out  1  PSLVERR, decode error or timeout.
- PADDR  out  ADDR_W  APB address.
- PSEL  out  NUM_SLAVES  one-hot slave select.
- PENABLE  out  1  APB access phase.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB strobes.
- PRDATA  in  NUM_SLAVES*DATA_W  slave i occupies bits [i*DATA_W +: DATA_W].
- PREADY  in  NUM_SLAVES  per-slave ready.
- PSLVERR  in  NUM_SLAVES  per-slave error.

Behaviour:
- Reset: while PRESET is sampled high, the next edge forces:
  - state to IDLE;
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB to 0;
  - rsp_valid, rsp_err, rsp_rdata to 0.
- req_ready = (state==IDLE) && !PRESET.
- Reset mid-transfer aborts the transfer immediately and produces no response.
- Decode: idx = req_addr >> REGION_BITS. If idx >= NUM_SLAVES, the request is a decode error.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - On req_valid && req_ready, capture addr, write, wdata and strb, plus idx.
  - Decode OK: go to SETUP.
  - Decode error: stay in IDLE, pulse rsp_valid=1, rsp_err=1, rsp_rdata=0 on the next cycle, and generate no APB activity.
- SETUP (one cycle):
  - PSEL[idx]=1, PENABLE=0, and PADDR/PWRITE/PWDATA driven from the captured command.
  - PSTRB = captured strb for writes, all-zero for reads.
  - Go to ACCESS.
- ACCESS:
  - PENABLE=1. All APB outputs are held stable until PREADY[idx] is sampled high.
  - On PREADY[idx]: register rsp_rdata = read ? PRDATA slice idx : 0, and rsp_err = PSLVERR[idx].
  - In the same edge, drive PSEL=0 and PENABLE=0, go to IDLE, and pulse rsp_valid for one cycle.
- Latency with zero wait states: accept at edge T, SETUP in T..T+1, ACCESS in T+1..T+2, rsp_valid high during T+2..T+3. Each wait state adds one cycle.
- Back-to-back: req_ready is high in the rsp_valid cycle, so a new command accepted there gives SETUP in the next cycle. Back-to-back throughput is 3 cycles per transfer.
- PREADY and PSLVERR of unselected slaves are ignored.
- PSEL is never multi-hot.
- rsp has no backpressure; the consumer must take it in the pulse cycle.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY[idx]=0.
  - When it reaches TIMEOUT, the next edge drops PSEL and PENABLE, returns to IDLE, and pulses rsp_valid with rsp_err=1 and rsp_rdata=0.
  - If PREADY arrives in the same cycle the limit is hit, PREADY wins: normal completion.
- Not defined: no counter is built, and ACCESS waits indefinitely for PREADY.

Decomposition:
- Shared package apb_pkg:
  - state enum (IDLE, SETUP, ACCESS);
  - default width constants;
  - STRB_W = DATA_W/8 helper.
- One natural sub-module, apb_addr_decode: combinational; takes addr and produces idx, one-hot sel and dec_err.

Test Plan:
- Write addr 2, data 6, strb 1; slave 0 PREADY tied high. Expect:
  - PSEL=001 in SETUP, then PENABLE=1 for one cycle;
  - PSTRB=1;
  - rsp_valid 3 cycles after accept with rsp_err=0.
- Write addr 98, data 63, then read addr 98 on slave 1 with PRDATA1=63 and 2 wait states. Expect:
  - PSEL=010 held 4 cycles;
  - PSTRB=0 on the read;
  - rsp_rdata=63, 5 cycles after accept.
- Read addr 200 (idx 3 >= 3). Expect:
  - no PSEL or PENABLE activity;
  - rsp_valid with rsp_err=1 and rsp_rdata=0 on the next cycle.
- Write addr 130 (slave 2) with PSLVERR2=1 at PREADY. Expect rsp_err=1, then back-to-back read addr 15 accepted in the rsp_valid cycle.
- Assert PRESET during ACCESS on slave 1. Expect:
  - PSEL, PENABLE and rsp_valid at 0 after the next edge;
  - no response pulse;
  - req_ready=1 once PRESET deasserts.
- APB_TIMEOUT_EN, TIMEOUT=16, slave 0 PREADY held low. Expect rsp_err=1 and PSEL=0 after 16 ACCESS cycles. Without the macro, the transfer still waits at cycle 100.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and defaults for the multi-slave APB4 master bridge.
// Build option: APB_TIMEOUT_EN (consumed by apb_master_mc).
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 8;
  localparam int DEF_NUM_SLAVES  = 3;
  localparam int DEF_REGION_BITS = 6;
  localparam int DEF_TIMEOUT     = 16;

  function automatic int strb_w(input int data_w);
    return data_w / 8;
  endfunction

  // Slave index width; kept at least 1 so a single-slave build still has a bit.
  function automatic int sel_w(input int num_slaves);
    return (num_slaves > 1) ? $clog2(num_slaves) : 1;
  endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational region decoder: slave index, one-hot select and decode error
// from a byte address split into 2**REGION_BITS sized windows.
module apb_addr_decode
  import apb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int REGION_BITS = DEF_REGION_BITS,
  parameter int SEL_W       = sel_w(DEF_NUM_SLAVES)
) (
  input  logic [ADDR_W-1:0]     i_addr,
  output logic [SEL_W-1:0]      o_idx,
  output logic [NUM_SLAVES-1:0] o_sel,
  output logic                  o_dec_err
);

  logic [ADDR_W-1:0] w_region;

  assign w_region  = i_addr >> REGION_BITS;
  assign o_dec_err = (w_region >= ADDR_W'(NUM_SLAVES));
  assign o_idx     = w_region[SEL_W-1:0];

  always_comb begin
    o_sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      o_sel[i] = !o_dec_err && (w_region == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/apb_master_mc.sv
// Multi-slave APB4 master bridge: one command at a time, SETUP/ACCESS with
// wait states, byte strobes and error capture. Option: APB_TIMEOUT_EN.
module apb_master_mc
  import apb_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int NUM_SLAVES  = DEF_NUM_SLAVES,
  parameter int REGION_BITS = DEF_REGION_BITS,
  parameter int TIMEOUT     = DEF_TIMEOUT
) (
  input  logic                         PCLK,
  input  logic                         PRESET,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  input  logic [DATA_W/8-1:0]          req_strb,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  output logic [ADDR_W-1:0]            PADDR,
  output logic [NUM_SLAVES-1:0]        PSEL,
  output logic                         PENABLE,
  output logic                         PWRITE,
  output logic [DATA_W-1:0]            PWDATA,
  output logic [DATA_W/8-1:0]          PSTRB,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR,
  output apb_state_t                   o_dbg_state
);

  localparam int STRB_W = strb_w(DATA_W);
  localparam int SEL_W  = sel_w(NUM_SLAVES);

  apb_state_t              r_state, w_state_nxt;
  logic [SEL_W-1:0]        r_idx, w_idx;
  logic [NUM_SLAVES-1:0]   w_sel, r_psel;
  logic                    w_dec_err, w_accept, w_ready, w_slverr, w_timeout;
  logic [DATA_W-1:0]       w_slice;
  logic [ADDR_W-1:0]       r_paddr;
  logic                    r_penable, r_pwrite;
  logic [DATA_W-1:0]       r_pwdata, r_rsp_rdata;
  logic [STRB_W-1:0]       r_pstrb;
  logic                    r_rsp_valid, r_rsp_err;

  apb_addr_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_SLAVES  (NUM_SLAVES),
    .REGION_BITS (REGION_BITS),
    .SEL_W       (SEL_W)
  ) u_decode (
    .i_addr    (req_addr),
    .o_idx     (w_idx),
    .o_sel     (w_sel),
    .o_dec_err (w_dec_err)
  );

  // Command handshake: a command transfers on the edge where req_valid and
  // req_ready are both high; ready is only offered in IDLE and never in reset.
  assign req_ready = (r_state == IDLE) && !PRESET;
  assign w_accept  = req_valid && req_ready;
  // Masking with the live select ignores ready/error from unselected slaves.
  assign w_ready   = |(PREADY & r_psel);
  assign w_slverr  = |(PSLVERR & r_psel);
  assign w_slice   = PRDATA[r_idx*DATA_W +: DATA_W];

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_to_cnt;

  // Fires on the TIMEOUT-th stalled ACCESS cycle; a same-cycle PREADY wins.
  assign w_timeout = (r_state == ACCESS) && !w_ready && (r_to_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge PCLK) begin
    if (PRESET || r_state != ACCESS) begin
      r_to_cnt <= '0;
    end else if (!w_ready && !w_timeout) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept && !w_dec_err) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (w_ready || w_timeout) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_psel      <= '0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_idx       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
      case (r_state)
        IDLE: begin
          if (w_accept && w_dec_err) begin
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
          end else if (w_accept) begin
            r_psel   <= w_sel;
            r_paddr  <= req_addr;
            r_pwrite <= req_write;
            r_pwdata <= req_wdata;
            r_pstrb  <= req_write ? req_strb : '0;
            r_idx    <= w_idx;
          end
        end
        SETUP: r_penable <= 1'b1;
        ACCESS: begin
          if (w_ready || w_timeout) begin
            r_psel      <= '0;
            r_penable   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= w_ready ? w_slverr : 1'b1;
            r_rsp_rdata <= (w_ready && !r_pwrite && !w_slverr) ? w_slice : '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PSTRB       = r_pstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_rdata   = r_rsp_rdata;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_master_mc.sv
// Directed bench for apb_master_mc: vector table of transfers plus reset-abort
// and stalled-slave sequences (the latter honours APB_TIMEOUT_EN).
module tb_apb_master_mc;
  import apb_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int NS     = 3;

  logic              PCLK = 1'b0;
  logic              PRESET;
  logic              req_valid, req_ready, req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [0:0]        req_strb;
  logic              rsp_valid, rsp_err;
  logic [DATA_W-1:0] rsp_rdata;
  logic [ADDR_W-1:0] PADDR;
  logic [NS-1:0]     PSEL;
  logic              PENABLE, PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [0:0]        PSTRB;
  logic [NS*DATA_W-1:0] PRDATA;
  logic [NS-1:0]     PREADY, PSLVERR;
  apb_state_t        dbg_state;

  apb_master_mc #(.ADDR_W(8), .DATA_W(8), .NUM_SLAVES(3), .REGION_BITS(6), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR), .o_dbg_state(dbg_state)
  );

  // clock / watchdog
  always #5 PCLK = ~PCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wdata;
    logic        strb;
    int          waits;
    logic [7:0]  prdata;
    logic        slverr;
    logic        b2b;
    logic [2:0]  exp_psel;
    logic        exp_strb;
    logic [7:0]  exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  logic [DATA_W:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver: present a command and program the slave-side inputs
  task automatic drive(input vec_t v, input bit push);
    req_valid = 1'b1;
    req_write = v.wr;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    PRDATA    = {NS{~v.prdata}};
    for (int s = 0; s < NS; s++) if (v.exp_psel[s]) PRDATA[s*DATA_W +: DATA_W] = v.prdata;
    PREADY  = ~v.exp_psel;
    PSLVERR = ~v.exp_psel | (v.slverr ? v.exp_psel : 3'b000);
    check("req_ready_at_issue", {31'd0, req_ready}, 32'd1);
    if (push) exp_q.push_back({v.exp_err, v.exp_rdata});
  endtask

  task automatic observe(input int i);
    vec_t v;
    int n, psel_cyc, pen_cyc, acc;
    bit stable_ok, got;
    logic [DATA_W:0] e;
    v = vecs[i];
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    n = 1; psel_cyc = 0; pen_cyc = 0; acc = 0; stable_ok = 1'b1; got = 1'b0;
    while (n <= 60) begin
      if (rsp_valid) begin
        got = 1'b1;
        break;
      end
      if (n == 1 && v.exp_psel != 3'b000) begin
        check("setup_psel", {29'd0, PSEL}, {29'd0, v.exp_psel});
        check("setup_penable", {31'd0, PENABLE}, 32'd0);
        check("setup_paddr", {24'd0, PADDR}, {24'd0, v.addr});
        check("setup_pwrite", {31'd0, PWRITE}, {31'd0, v.wr});
        check("setup_pwdata", {24'd0, PWDATA}, {24'd0, v.wdata});
        check("setup_pstrb", {31'd0, PSTRB}, {31'd0, v.exp_strb});
      end
      if (PSEL != 3'b000) psel_cyc++;
      if (PENABLE) pen_cyc++;
      if (PSEL != 3'b000 && (PSEL != v.exp_psel || PADDR != v.addr ||
                             PWRITE != v.wr || PSTRB != v.exp_strb)) stable_ok = 1'b0;
      if (PENABLE) begin
        if (acc == v.waits) PREADY = 3'b111;
        acc++;
      end
      @(negedge PCLK);
      n++;
    end
    check("rsp_arrived", {31'd0, got}, 32'd1);
    if (got) begin
      check("latency", n, v.exp_lat);
      check("psel_cycles", psel_cyc, (v.exp_psel != 3'b000) ? 2 + v.waits : 0);
      check("penable_cycles", pen_cyc, (v.exp_psel != 3'b000) ? 1 + v.waits : 0);
      check("apb_stable", {31'd0, stable_ok}, 32'd1);
      check("rsp_psel_idle", {29'd0, PSEL}, 32'd0);
      check("rsp_penable_idle", {31'd0, PENABLE}, 32'd0);
      check("rsp_req_ready", {31'd0, req_ready}, 32'd1);
      if (exp_q.size() == 0) begin
        check("sb_unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_err", {31'd0, rsp_err}, {31'd0, e[DATA_W]});
        check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e[DATA_W-1:0]});
      end
      PREADY  = 3'b000;
      PSLVERR = 3'b000;
      if (i + 1 < NV && vecs[i+1].b2b) drive(vecs[i+1], 1'b1);
    end
  endtask

  initial begin
    vec_t rv, tv;
    int n;
    bit seen;

    //       wr    addr   wdata  strb wt prdata slverr b2b  psel    estrb erdata err lat
    vecs[0]  = '{1'b1, 8'd2,   8'd6,  1'b1, 0, 8'h00, 1'b0, 1'b0, 3'b001, 1'b1, 8'h00, 1'b0, 3};
    vecs[1]  = '{1'b1, 8'd98,  8'd63, 1'b1, 0, 8'h00, 1'b0, 1'b0, 3'b010, 1'b1, 8'h00, 1'b0, 3};
    vecs[2]  = '{1'b0, 8'd98,  8'd0,  1'b1, 2, 8'd63, 1'b0, 1'b0, 3'b010, 1'b0, 8'd63, 1'b0, 5};
    vecs[3]  = '{1'b0, 8'd200, 8'd0,  1'b0, 0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1, 1};
    vecs[4]  = '{1'b1, 8'd130, 8'hA5, 1'b1, 1, 8'h00, 1'b1, 1'b0, 3'b100, 1'b1, 8'h00, 1'b1, 4};
    vecs[5]  = '{1'b0, 8'd15,  8'd0,  1'b0, 0, 8'h3C, 1'b0, 1'b1, 3'b001, 1'b0, 8'h3C, 1'b0, 3};
    vecs[6]  = '{1'b0, 8'd64,  8'd0,  1'b0, 1, 8'h81, 1'b0, 1'b0, 3'b010, 1'b0, 8'h81, 1'b0, 4};
    vecs[7]  = '{1'b0, 8'd191, 8'd0,  1'b0, 0, 8'hEE, 1'b0, 1'b0, 3'b100, 1'b0, 8'hEE, 1'b0, 3};
    vecs[8]  = '{1'b0, 8'd150, 8'd0,  1'b0, 0, 8'h77, 1'b1, 1'b0, 3'b100, 1'b0, 8'h00, 1'b1, 3};
    vecs[9]  = '{1'b1, 8'd63,  8'h5A, 1'b0, 3, 8'h00, 1'b0, 1'b0, 3'b001, 1'b0, 8'h00, 1'b0, 6};
    vecs[10] = '{1'b1, 8'd192, 8'd11, 1'b1, 0, 8'h00, 1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 1'b1, 1};
    vecs[11] = '{1'b0, 8'd255, 8'd0,  1'b0, 0, 8'h00, 1'b0, 1'b1, 3'b000, 1'b0, 8'h00, 1'b1, 1};

    // reset
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; PRDATA = '0; PREADY = '0; PSLVERR = '0;
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    check("ready_in_reset", {31'd0, req_ready}, 32'd0);
    PRESET = 1'b0;
    #1;
    check("reset_req_ready", {31'd0, req_ready}, 32'd1);
    check("reset_psel", {29'd0, PSEL}, 32'd0);
    check("reset_penable", {31'd0, PENABLE}, 32'd0);
    check("reset_pwrite", {31'd0, PWRITE}, 32'd0);
    check("reset_paddr", {24'd0, PADDR}, 32'd0);
    check("reset_pwdata", {24'd0, PWDATA}, 32'd0);
    check("reset_pstrb", {31'd0, PSTRB}, 32'd0);
    check("reset_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    // table-driven transfers
    for (int i = 0; i < NV; i++) begin
      if (!vecs[i].b2b) begin
        @(negedge PCLK);
        check("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);
        check("idle_psel", {29'd0, PSEL}, 32'd0);
        drive(vecs[i], 1'b1);
      end
      observe(i);
    end

    // reset during ACCESS on slave 1 aborts with no response
    rv = '{1'b0, 8'd98, 8'd0, 1'b0, 0, 8'h55, 1'b0, 1'b0, 3'b010, 1'b0, 8'h00, 1'b0, 0};
    @(negedge PCLK);
    drive(rv, 1'b0);
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    check("abort_in_access", {31'd0, PENABLE}, 32'd1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("abort_psel", {29'd0, PSEL}, 32'd0);
    check("abort_penable", {31'd0, PENABLE}, 32'd0);
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_state", 32'(dbg_state), 32'(IDLE));
    PRESET = 1'b0;
    PREADY = 3'b111;
    #1;
    check("abort_ready_after", {31'd0, req_ready}, 32'd1);
    seen = 1'b0;
    repeat (5) begin
      @(negedge PCLK);
      if (rsp_valid) seen = 1'b1;
    end
    check("abort_no_rsp", {31'd0, seen}, 32'd0);
    PREADY = 3'b000;

    // stalled slave 0: PREADY held low
    tv = '{1'b0, 8'd5, 8'd0, 1'b0, 0, 8'h42, 1'b0, 1'b0, 3'b001, 1'b0, 8'h42, 1'b0, 0};
    @(negedge PCLK);
    drive(tv, 1'b0);
    PREADY = 3'b000;
    @(posedge PCLK);
    @(negedge PCLK);
    req_valid = 1'b0;
    n = 1;
`ifdef APB_TIMEOUT_EN
    while (!rsp_valid && n < 60) begin
      @(negedge PCLK);
      n++;
    end
    check("to_latency", n, 18);
    check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    check("to_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    check("to_psel", {29'd0, PSEL}, 32'd0);
    check("to_penable", {31'd0, PENABLE}, 32'd0);
`else
    seen = 1'b0;
    repeat (100) begin
      @(negedge PCLK);
      if (rsp_valid) seen = 1'b1;
    end
    check("stall_no_rsp", {31'd0, seen}, 32'd0);
    check("stall_psel", {29'd0, PSEL}, 32'd1);
    check("stall_penable", {31'd0, PENABLE}, 32'd1);
    PREADY = 3'b001;
    @(negedge PCLK);
    check("stall_release_valid", {31'd0, rsp_valid}, 32'd1);
    check("stall_release_err", {31'd0, rsp_err}, 32'd0);
    check("stall_release_rdata", {24'd0, rsp_rdata}, 32'h42);
`endif
    PREADY = 3'b000;
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
